// File: rtl/ula_seq_pkg.sv
// Shared opcode encodings and FSM state type for ula_seq and its testbench.
package ula_seq_pkg;

   localparam logic [4:0] OP_ADD = 5'b00000;
   localparam logic [4:0] OP_SUB = 5'b00001;
   localparam logic [4:0] OP_SLT = 5'b00010;
   localparam logic [4:0] OP_MUL = 5'b00011;
   localparam logic [4:0] OP_NEQ = 5'b00100;
   localparam logic [4:0] OP_DIV = 5'b00101;
   localparam logic [4:0] OP_SHL = 5'b00110;
   localparam logic [4:0] OP_SHR = 5'b00111;
   localparam logic [4:0] OP_NOT = 5'b01000;
   localparam logic [4:0] OP_AND = 5'b01001;
   localparam logic [4:0] OP_OR  = 5'b01010;
   localparam logic [4:0] OP_XOR = 5'b01011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic is_iterative(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/ula_seq_if.sv
// Handshake bus of ula_seq; the ovf signal exists only when ULA_OVF_DETECT_EN is defined.
interface ula_seq_if #(
   parameter int unsigned WIDTH = 32
) ();
   localparam int unsigned SHW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [4:0]       op;
   logic [WIDTH-1:0] data1;
   logic [WIDTH-1:0] data2;
   logic [SHW-1:0]   shamt;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             busy;
`ifdef ULA_OVF_DETECT_EN
   logic             ovf;
`endif

   modport slave (
      input  in_valid, op, data1, data2, shamt, out_ready,
      output in_ready, out_valid, result, zero, busy
`ifdef ULA_OVF_DETECT_EN
      , output ovf
`endif
   );

   modport master (
      output in_valid, op, data1, data2, shamt, out_ready,
      input  in_ready, out_valid, result, zero, busy
`ifdef ULA_OVF_DETECT_EN
      , input ovf
`endif
   );

endinterface

// File: rtl/ula_seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock, WIDTH steps; divisor 0 is replaced by 1.
module ula_seq_divider #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] quotient
);
   localparam int unsigned CW = $clog2(WIDTH);

   logic             run;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem, quo, dvs;
   logic [WIDTH:0]   trial, diff;
   logic             ge;
   logic [WIDTH-1:0] rem_next, quo_next;
   logic             last;

   always_comb begin
      trial    = {rem, quo[WIDTH-1]};
      diff     = trial - {1'b0, dvs};
      ge       = (trial >= {1'b0, dvs});
      rem_next = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], ge};
   end

   assign last = (cnt == CW'(WIDTH - 1));
   // done and quotient describe the step completing on this edge, so the caller can register them directly
   assign done     = run & last;
   assign quotient = quo_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run <= 1'b0;
         cnt <= '0;
         rem <= '0;
         quo <= '0;
         dvs <= '0;
      end else if (start) begin
         run <= 1'b1;
         cnt <= '0;
         rem <= '0;
         quo <= dividend;
         dvs <= (divisor == '0) ? WIDTH'(1) : divisor;
      end else if (run) begin
         rem <= rem_next;
         quo <= quo_next;
         if (last) run <= 1'b0;
         else      cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/ula_seq.sv
// Handshaked sequential ULA: single-cycle ops, shift-add MUL, restoring DIV.
// Optional signed-overflow flag enabled by defining ULA_OVF_DETECT_EN.
module ula_seq
   import ula_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input logic     clk,
   input logic     rst_n,
   ula_seq_if.slave bus
);
   localparam int unsigned HALF = WIDTH / 2;
   localparam int unsigned CW   = $clog2(WIDTH);

   state_t           state, state_next;
   logic             in_ready_q;
   logic             accept;
   logic             is_div_q;
   logic [CW-1:0]    cnt;
   logic [HALF-1:0]  mplier;
   logic [WIDTH-1:0] mcand, acc, acc_next;
   logic [WIDTH-1:0] alu_res, result_q, iter_res;
   logic             zero_q;
   logic             mul_last, iter_last;
   logic             div_done;
   logic [WIDTH-1:0] div_quo;
`ifdef ULA_OVF_DETECT_EN
   logic             ovf_next, ovf_q;
`endif

   assign accept   = bus.in_valid & in_ready_q;
   assign mul_last = (cnt == CW'(HALF - 1));
   assign acc_next = acc + (mplier[0] ? mcand : '0);

   ula_seq_divider #(.WIDTH(WIDTH)) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (accept && (bus.op == OP_DIV)),
      .dividend (bus.data1),
      .divisor  (bus.data2),
      .done     (div_done),
      .quotient (div_quo)
   );

   always_comb begin
      alu_res = '0;
      unique case (bus.op)
         OP_ADD:  alu_res = bus.data1 + bus.data2;
         OP_SUB:  alu_res = bus.data1 - bus.data2;
         OP_SLT:  alu_res = WIDTH'(bus.data1 < bus.data2);
         OP_NEQ:  alu_res = WIDTH'(bus.data1 != bus.data2);
         OP_SHL:  alu_res = bus.data1 << bus.shamt;
         OP_SHR:  alu_res = bus.data1 >> bus.shamt;
         OP_NOT:  alu_res = ~bus.data1;
         OP_AND:  alu_res = bus.data1 & bus.data2;
         OP_OR:   alu_res = bus.data1 | bus.data2;
         OP_XOR:  alu_res = bus.data1 ^ bus.data2;
         default: alu_res = '0;
      endcase
   end

`ifdef ULA_OVF_DETECT_EN
   always_comb begin
      ovf_next = 1'b0;
      if (bus.op == OP_ADD)
         ovf_next = (bus.data1[WIDTH-1] == bus.data2[WIDTH-1]) && (alu_res[WIDTH-1] != bus.data1[WIDTH-1]);
      else if (bus.op == OP_SUB)
         ovf_next = (bus.data1[WIDTH-1] != bus.data2[WIDTH-1]) && (alu_res[WIDTH-1] != bus.data1[WIDTH-1]);
   end
`endif

   always_comb begin
      iter_last = is_div_q ? div_done : mul_last;
      iter_res  = is_div_q ? div_quo  : acc_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: if (accept)        state_next = is_iterative(bus.op) ? ST_ITER : ST_DONE;
         ST_ITER: if (iter_last)     state_next = ST_DONE;
         ST_DONE: if (bus.out_ready) state_next = ST_IDLE;
         default:                    state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_q <= 1'b0;
         is_div_q   <= 1'b0;
         cnt        <= '0;
         mplier     <= '0;
         mcand      <= '0;
         acc        <= '0;
         result_q   <= '0;
         zero_q     <= 1'b0;
`ifdef ULA_OVF_DETECT_EN
         ovf_q      <= 1'b0;
`endif
      end else begin
         // registered from next state so ready stays low for the first cycle after reset release
         in_ready_q <= (state_next == ST_IDLE);
         if (accept) begin
            is_div_q <= (bus.op == OP_DIV);
            cnt      <= '0;
            mplier   <= bus.data1[HALF-1:0];
            mcand    <= WIDTH'(bus.data2[HALF-1:0]);
            acc      <= '0;
            if (!is_iterative(bus.op)) begin
               result_q <= alu_res;
               zero_q   <= (alu_res == '0);
`ifdef ULA_OVF_DETECT_EN
               ovf_q    <= ovf_next;
`endif
            end
         end else if (state == ST_ITER) begin
            if (!is_div_q) begin
               mplier <= mplier >> 1;
               mcand  <= mcand << 1;
               acc    <= acc_next;
               if (!mul_last) cnt <= cnt + CW'(1);
            end
            if (iter_last) begin
               result_q <= iter_res;
               zero_q   <= (iter_res == '0);
`ifdef ULA_OVF_DETECT_EN
               ovf_q    <= 1'b0;
`endif
            end
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = (state == ST_DONE);
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.busy      = (state != ST_IDLE);
`ifdef ULA_OVF_DETECT_EN
   assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_ula_seq.sv
// Self-checking bench for ula_seq (WIDTH=32): directed cases plus random ops against a behavioural model.
module tb_ula_seq;
   import ula_seq_pkg::*;

   localparam int unsigned W = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int unsigned passed = 0;
   int unsigned total  = 0;

   ula_seq_if #(.WIDTH(W)) bus ();
   ula_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] sh);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_SLT:  return (a < b) ? 32'd1 : 32'd0;
         OP_MUL:  return (a % 32'd65536) * (b % 32'd65536);
         OP_NEQ:  return (a == b) ? 32'd0 : 32'd1;
         OP_DIV:  return (b == 0) ? a : a / b;
         OP_SHL:  return a << sh;
         OP_SHR:  return a >> sh;
         OP_NOT:  return ~a;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int lat_of(input logic [4:0] op);
      if (op == OP_MUL) return W / 2 + 1;
      if (op == OP_DIV) return W + 1;
      return 1;
   endfunction

`ifdef ULA_OVF_DETECT_EN
   function automatic logic ovf_of(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, s;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (op == OP_ADD)      s = sa + sb;
      else if (op == OP_SUB) s = sa - sb;
      else                   return 1'b0;
      return (s > 64'sd2147483647) || (s < -64'sd2147483648);
   endfunction
`endif

   task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input int bp);
      logic [31:0] exp_res;
      int exp_lat, lat;
      bit rdy_bad, busy_bad, hold_bad;
      exp_res = model(op, a, b, sh);
      exp_lat = lat_of(op);
      @(negedge clk);
      chk({tag, " ready"}, 32'(bus.in_ready), 32'd1);
      bus.op        = op;
      bus.data1     = a;
      bus.data2     = b;
      bus.shamt     = sh;
      bus.in_valid  = 1'b1;
      bus.out_ready = (bp == 0);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.op       = 5'($urandom);
      bus.data1    = $urandom;
      bus.data2    = $urandom;
      bus.shamt    = 5'($urandom);
      lat = 1;
      rdy_bad = 1'b0;
      busy_bad = 1'b0;
      while (!bus.out_valid && lat < 200) begin
         if (bus.in_ready) rdy_bad = 1'b1;
         if (!bus.busy)    busy_bad = 1'b1;
         @(negedge clk);
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, " result"}, bus.result, exp_res);
      chk({tag, " zero"}, 32'(bus.zero), 32'(exp_res == 0));
`ifdef ULA_OVF_DETECT_EN
      chk({tag, " ovf"}, 32'(bus.ovf), 32'(ovf_of(op, a, b)));
`endif
      if (exp_lat > 1) chk({tag, " iter ready/busy"}, {30'd0, rdy_bad, busy_bad}, 32'd0);
      if (bp > 0) begin
         hold_bad = 1'b0;
         repeat (bp) begin
            @(negedge clk);
            if (!bus.out_valid || bus.in_ready || bus.result !== exp_res || bus.zero !== (exp_res == 0))
               hold_bad = 1'b1;
         end
         chk({tag, " hold"}, 32'(hold_bad), 32'd0);
         bus.out_ready = 1'b1;
      end
      @(negedge clk);
      chk({tag, " release"}, {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
   endtask

   initial begin
      bit seen_valid;
      logic [4:0] rop;
      logic [31:0] ra, rb;

      bus.in_valid  = 1'b0;
      bus.op        = '0;
      bus.data1     = '0;
      bus.data2     = '0;
      bus.shamt     = '0;
      bus.out_ready = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst result", bus.result, 32'd0);
      chk("rst zero", 32'(bus.zero), 32'd0);
      chk("rst busy", 32'(bus.busy), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rel in_ready pre-clk", 32'(bus.in_ready), 32'd0);

      do_op("add7+5", OP_ADD, 32'd7, 32'd5, 5'd0, 0);
      do_op("sub5-5", OP_SUB, 32'd5, 32'd5, 5'd0, 0);
      do_op("mul trunc", OP_MUL, 32'h0001_FFFF, 32'h0000_0003, 5'd0, 0);
      do_op("mul max", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 0);
      do_op("div100/7", OP_DIV, 32'd100, 32'd7, 5'd0, 0);
      do_op("div100/0", OP_DIV, 32'd100, 32'd0, 5'd0, 0);
      do_op("xor bp", OP_XOR, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 5'd0, 5);
      do_op("slt eq", OP_SLT, 32'd9, 32'd9, 5'd0, 0);
      do_op("shl31", OP_SHL, 32'h0000_0003, 32'd0, 5'd31, 0);
      do_op("shr31", OP_SHR, 32'h8000_0000, 32'd0, 5'd31, 0);
      do_op("undef op", 5'b11111, 32'h1234_5678, 32'h1, 5'd3, 0);
      do_op("add ovf", OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, 0);
      do_op("sub ovf", OP_SUB, 32'h8000_0000, 32'd1, 5'd0, 0);

      // reset in the middle of a divide
      @(negedge clk);
      bus.op       = OP_DIV;
      bus.data1    = 32'd1000;
      bus.data2    = 32'd3;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst busy", 32'(bus.busy), 32'd0);
      chk("midrst in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen_valid = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.out_valid) seen_valid = 1'b1;
      end
      chk("midrst no result", 32'(seen_valid), 32'd0);
      do_op("add1+1", OP_ADD, 32'd1, 32'd1, 5'd0, 0);

      for (int i = 0; i < 40; i++) begin
         rop = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(12, 31)) : 5'($urandom_range(0, 11));
         ra  = $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         do_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, 5'($urandom), int'($urandom_range(0, 2)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
